// File: rtl/seg_mux_display.sv
// Time-multiplexed N-digit hex 7-segment driver with per-digit dead time and
// frame-synchronous double buffering of the digit values and blank flags.
module seg_mux_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 20000,
  parameter int DEAD_CYCLES = 200
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SLOT_CYCLES);
  localparam logic [SW-1:0] S_LAST = SW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(SLOT_CYCLES - 1);
  localparam logic [PW-1:0] P_DEAD = PW'(DEAD_CYCLES);

  // ST_IDLE holds the scan at (0,0) for the first edge out of reset,
  // making that edge a frame boundary.
  typedef enum logic [1:0] {ST_IDLE, ST_DEAD, ST_DRIVE} state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           s_q, s_d;
  logic [PW-1:0]           p_q, p_d;
  logic                    boundary;
  logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d, pend_digits_q;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q;
  logic                    pend_valid_q;
  logic [6:0]              seg_d;
  logic [NUM_DIGITS-1:0]   an_d;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    s_d          = s_q;
    p_d          = p_q;
    boundary     = 1'b0;
    act_digits_d = act_digits_q;
    act_blank_d  = act_blank_q;
    seg_d        = '1;
    an_d         = '1;

    if (state_q == ST_IDLE) begin
      s_d      = '0;
      p_d      = '0;
      boundary = 1'b1;
    end else if (p_q == P_LAST) begin
      p_d      = '0;
      s_d      = (s_q == S_LAST) ? '0 : s_q + 1'b1;
      boundary = (s_q == S_LAST);
    end else begin
      p_d = p_q + 1'b1;
    end

    // A load on the boundary edge bypasses pending for zero-latency display.
    if (boundary) begin
      if (load) begin
        act_digits_d = digits;
        act_blank_d  = blank;
      end else if (pend_valid_q) begin
        act_digits_d = pend_digits_q;
        act_blank_d  = pend_blank_q;
      end
    end

    state_d = ((DEAD_CYCLES != 0) && (p_d < P_DEAD)) ? ST_DEAD : ST_DRIVE;

    if (state_d == ST_DRIVE && !act_blank_d[s_d]) begin
      an_d[s_d] = 1'b0;
      seg_d     = decode(act_digits_d[s_d*4 +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      s_q           <= '0;
      p_q           <= '0;
      act_digits_q  <= '0;
      act_blank_q   <= '1;
      pend_digits_q <= '0;
      pend_blank_q  <= '1;
      pend_valid_q  <= 1'b0;
      seg           <= '1;
      an            <= '1;
      frame_done    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      p_q          <= p_d;
      act_digits_q <= act_digits_d;
      act_blank_q  <= act_blank_d;
      if (boundary) begin
        pend_valid_q <= 1'b0;
      end else if (load) begin
        pend_digits_q <= digits;
        pend_blank_q  <= blank;
        pend_valid_q  <= 1'b1;
      end
      seg        <= seg_d;
      an         <= an_d;
      frame_done <= boundary;
    end
  end

endmodule
